uart_transceiver: RTL
=====================

# uart_transceiver

Parametrised full-duplex UART core running directly on the 100 MHz system clock with an internal oversampling tick generator, replacing the separate 10 kHz clock domain, receiver and transmitter. It sits between the board's USB-UART pins (TXD in, RXD out) and user logic. It exposes a valid/ready transmit handshake and a pulsed receive strobe with error flags. It also adds glitch-rejecting start detection, configurable frame format and optional parity.

## Interface
- CLOCK_HZ, 100_000_000, system clock frequency
- BAUD, 9600, line rate
- OVERSAMPLE, 16, ticks per bit; even, 8..16
- DATA_BITS, 8, payload width, 5..9, LSB first
- STOP_BITS, 1, stop bits transmitted, 1 or 2
- PARITY_ODD, 0, 0 = even, 1 = odd; used only with UART_PARITY_EN
- Clock_100MHz  in  1  system clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- TXD  in  1  serial input from host, idle high
- RXD  out  1  serial output to host, idle high
- Tx_Data  in  DATA_BITS  byte to send
- Tx_Valid  in  1  Tx_Data is valid
- Tx_Ready  out  1  transmitter accepts a byte this cycle
- Rx_Data  out  DATA_BITS  last received byte
- Rx_Valid  out  1  one-cycle strobe: new Rx_Data and flags
- Rx_Frame_Error  out  1  stop bit sampled low
- Rx_Parity_Error  out  1  parity mismatch; constant 0 without UART_PARITY_EN

## Operation
- Reset: RXD=1, Tx_Ready=1, Rx_Data=0, Rx_Valid=0, both error flags 0, both FSMs IDLE, tick counter 0, synchroniser flops 1.
- Tick generator: DIV = round(CLOCK_HZ/(BAUD*OVERSAMPLE)), minimum 1. Counter runs 0..DIV-1 and is free-running. `tick` is high for one cycle when the counter equals DIV-1.
- TX FSM: IDLE, START, DATA, PARITY, STOP.
  - IDLE: Tx_Ready=1. Tx_Valid && Tx_Ready latches Tx_Data into the shift register, drops Tx_Ready next cycle and moves to START.
  - Each bit lasts OVERSAMPLE ticks and is counted by a tick counter.
  - DATA shifts DATA_BITS bits, LSB first.
  - PARITY is present only with the macro.
  - STOP lasts STOP_BITS bit periods.
  - After the final stop period the FSM returns to IDLE and raises Tx_Ready.
  - Tx_Valid with Tx_Ready low is ignored. Tx_Data may change freely after acceptance.
- RX path: 2-flop synchroniser on TXD. RX FSM: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a synchronised low moves to START and clears the tick phase counter.
  - START: sample at tick OVERSAMPLE/2. If the sample is high, treat it as a glitch and return to IDLE with no strobe.
  - Each later bit is sampled every OVERSAMPLE ticks from the start sample, i.e. at mid-bit.
  - STOP: sample once, then assert Rx_Valid for one cycle. Rx_Data and both flags update in the same cycle and hold until the next strobe. The FSM returns to IDLE immediately, half a bit early, so it can resynchronise.
  - A framing error still strobes Rx_Valid with Rx_Frame_Error=1.
  - RX checks only the first stop bit regardless of STOP_BITS.
  - A break (line held low) yields one framed-error strobe, then IDLE waits for the line to go high before it can detect a new start.
- TX and RX are fully independent. Simultaneous activity has no interaction.

## Timing
- Bit period = OVERSAMPLE*DIV cycles. At the defaults, DIV=651, giving 10416 cycles per bit (9600.6 baud).
- Handshake to RXD falling edge: 1..DIV cycles, because the start bit begins on the next tick.
- Back-to-back: Tx_Valid held high is accepted in the cycle after Tx_Ready rises. Line idle between frames is at most DIV cycles.
- RX latency: Rx_Valid fires 2 cycles (synchroniser) plus the mid-stop-bit sample tick plus 1 cycle after the true mid-stop point.
- Reset asserted mid-frame aborts both FSMs at once. RXD goes high asynchronously and no Rx_Valid is issued.

## Configuration
- UART_PARITY_EN defined:
  - TX inserts a parity bit after the data bits: the XOR of the data, inverted when PARITY_ODD=1.
  - RX samples the parity bit and sets Rx_Parity_Error on mismatch.
  - A frame is 1+DATA_BITS+1+STOP_BITS bits.
- UART_PARITY_EN undefined:
  - No PARITY state exists in either FSM.
  - Rx_Parity_Error is tied to 0.
  - PARITY_ODD is ignored.

## Structure
- Package uart_pkg holds the following, shared with future UART blocks:
  - tx_state_t and rx_state_t enums
  - divisor function calc_div(CLOCK_HZ, BAUD, OVERSAMPLE)
  - localparam widths for the tick and bit counters
- One sub-module, uart_baud_tick, holds the tick generator, parametrised by DIV. The TX and RX FSMs stay in uart_transceiver.

## Test plan
Bench parameters: CLOCK_HZ=1_600_000, BAUD=10_000, OVERSAMPLE=16, giving DIV=10 and 160 cycles per bit.
- Reset check: after reset, RXD=1, Tx_Ready=1, Rx_Valid=0 and Rx_Data=0. Assert Reset_n low mid-TX frame → RXD=1 within the same cycle.
- TX 0x55 → RXD shows start 0, then 1,0,1,0,1,0,1,0, then stop 1; each bit is 160 cycles. Tx_Ready is low for the whole frame (1600 cycles, ±10 for tick alignment).
- Loopback RXD→TXD, with Tx_Valid held high over 0xA5, 0x3C, 0xFF → three Rx_Valid strobes with matching data, and no error flags.
- TXD pulsed low for 40 cycles, then high → no Rx_Valid, and the FSM returns to IDLE.
- Frame 0x81 with the stop bit forced low → Rx_Valid=1, Rx_Data=0x81, Rx_Frame_Error=1. The next good frame 0x00 clears the flag.
- With UART_PARITY_EN and PARITY_ODD=0: send 0x07 with parity bit 0 → Rx_Parity_Error=1. Send it with parity bit 1 → Rx_Parity_Error=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and helpers: FSM state enums, baud divisor function, counter widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    // Oversample phase counter covers 0..15 (OVERSAMPLE up to 16).
    localparam int OS_CNT_W  = 4;
    // Bit counter covers up to 9 data bits or 2 stop bits.
    localparam int BIT_CNT_W = 4;

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
`else
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`endif

    // Rounded system-clock cycles per oversample tick, never below 1.
    function automatic int calc_div(input longint clock_hz, input longint baud,
                                    input longint oversample);
        longint den;
        longint div;
        den = baud * oversample;
        div = (clock_hz + den / 2) / den;
        if (div < 1) div = 1;
        return int'(div);
    endfunction

endpackage

// File: rtl/uart_transceiver_if.sv
// User-side transmit handshake and receive strobe bundle for uart_transceiver.
// Latency: n/a (wires only).
// Backpressure: Tx_Valid/Tx_Ready handshake; Rx_Valid is a strobe with no backpressure.
interface uart_transceiver_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] Tx_Data;
    logic                 Tx_Valid;
    logic                 Tx_Ready;
    logic [DATA_BITS-1:0] Rx_Data;
    logic                 Rx_Valid;
    logic                 Rx_Frame_Error;
    logic                 Rx_Parity_Error;

    // User logic side
    modport master (
        output Tx_Data, Tx_Valid,
        input  Tx_Ready, Rx_Data, Rx_Valid, Rx_Frame_Error, Rx_Parity_Error
    );

    // UART core side
    modport slave (
        input  Tx_Data, Tx_Valid,
        output Tx_Ready, Rx_Data, Rx_Valid, Rx_Frame_Error, Rx_Parity_Error
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: counter 0..DIV-1, tick_o high while at DIV-1.
// Latency: tick_o is decoded from the registered counter, one pulse every DIV cycles.
// Backpressure: none, free-running.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);
    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    // Wrap the divider counter at DIV-1
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)            cnt_q <= '0;
        else if (cnt_q == LAST) cnt_q <= '0;
        else                    cnt_q <= cnt_q + CW'(1);
    end

    assign tick_o = (cnt_q == LAST);
endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex UART on the system clock with oversampled RX; optional parity via UART_PARITY_EN.
// Latency: TX line starts on the next tick after accept; Rx_Valid ~1 tick + 3 cycles after mid-stop.
// Backpressure: Tx_Ready low for the whole TX frame; Rx_Valid is a one-cycle strobe, never stalls.
module uart_transceiver
    import uart_pkg::*;
#(
    parameter int CLOCK_HZ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              Clock_100MHz,
    input  logic              Reset_n,
    input  logic              TXD,
    output logic              RXD,
    uart_transceiver_if.slave uif
);
    localparam int                   DIV       = calc_div(CLOCK_HZ, BAUD, OVERSAMPLE);
    localparam logic [OS_CNT_W-1:0]  OS_LAST   = OS_CNT_W'(OVERSAMPLE - 1);
    localparam logic [OS_CNT_W-1:0]  OS_MID    = OS_CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] STOP_LAST = BIT_CNT_W'(STOP_BITS - 1);

    if (OVERSAMPLE < 8 || OVERSAMPLE > 16 || (OVERSAMPLE % 2) != 0 ||
        DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_transceiver: unsupported parameter set");
    end

    logic tick;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk_i  (Clock_100MHz),
        .rst_ni (Reset_n),
        .tick_o (tick)
    );

    // ---------------- transmitter ----------------
    tx_state_t              tx_state_q;
    logic [DATA_BITS-1:0]   tx_shift_q;
    logic [OS_CNT_W-1:0]    tx_os_q;
    logic [BIT_CNT_W-1:0]   tx_bit_q;
    logic                   tx_arm_q;     // waiting for the first tick to open the start bit
    logic                   rxd_q;
    logic                   tx_ready_q;
    logic                   tx_bit_end;
`ifdef UART_PARITY_EN
    localparam logic        PAR_ODD = 1'(PARITY_ODD);
    logic                   tx_par_q;
`endif

    assign tx_bit_end   = tick && (tx_os_q == OS_LAST);
    assign RXD          = rxd_q;
    assign uif.Tx_Ready = tx_ready_q;

    // TX frame sequencer: every line transition is aligned to a tick
    always_ff @(posedge Clock_100MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '0;
            tx_os_q    <= '0;
            tx_bit_q   <= '0;
            tx_arm_q   <= 1'b0;
            rxd_q      <= 1'b1;
            tx_ready_q <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            case (tx_state_q)
                TX_IDLE: if (uif.Tx_Valid && tx_ready_q) begin
                    tx_shift_q <= uif.Tx_Data;
`ifdef UART_PARITY_EN
                    tx_par_q   <= (^uif.Tx_Data) ^ PAR_ODD;
`endif
                    tx_ready_q <= 1'b0;
                    tx_arm_q   <= 1'b1;
                    tx_os_q    <= '0;
                    tx_state_q <= TX_START;
                end
                TX_START: if (tick) begin
                    if (tx_arm_q) begin
                        rxd_q    <= 1'b0;
                        tx_arm_q <= 1'b0;
                    end else if (tx_os_q == OS_LAST) begin
                        tx_os_q    <= '0;
                        rxd_q      <= tx_shift_q[0];
                        tx_shift_q <= tx_shift_q >> 1;
                        tx_bit_q   <= '0;
                        tx_state_q <= TX_DATA;
                    end else begin
                        tx_os_q <= tx_os_q + OS_CNT_W'(1);
                    end
                end
                TX_DATA: if (tx_bit_end) begin
                    tx_os_q <= '0;
                    if (tx_bit_q == DATA_LAST) begin
`ifdef UART_PARITY_EN
                        rxd_q      <= tx_par_q;
                        tx_state_q <= TX_PARITY;
`else
                        rxd_q      <= 1'b1;
                        tx_bit_q   <= '0;
                        tx_state_q <= TX_STOP;
`endif
                    end else begin
                        rxd_q      <= tx_shift_q[0];
                        tx_shift_q <= tx_shift_q >> 1;
                        tx_bit_q   <= tx_bit_q + BIT_CNT_W'(1);
                    end
                end else if (tick) begin
                    tx_os_q <= tx_os_q + OS_CNT_W'(1);
                end
`ifdef UART_PARITY_EN
                TX_PARITY: if (tx_bit_end) begin
                    tx_os_q    <= '0;
                    rxd_q      <= 1'b1;
                    tx_bit_q   <= '0;
                    tx_state_q <= TX_STOP;
                end else if (tick) begin
                    tx_os_q <= tx_os_q + OS_CNT_W'(1);
                end
`endif
                TX_STOP: if (tx_bit_end) begin
                    tx_os_q <= '0;
                    if (tx_bit_q == STOP_LAST) begin
                        tx_ready_q <= 1'b1;
                        tx_state_q <= TX_IDLE;
                    end else begin
                        tx_bit_q <= tx_bit_q + BIT_CNT_W'(1);
                    end
                end else if (tick) begin
                    tx_os_q <= tx_os_q + OS_CNT_W'(1);
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    // ---------------- receiver ----------------
    logic                   sync1_q, sync2_q;
    rx_state_t              rx_state_q;
    logic [DATA_BITS-1:0]   rx_shift_q;
    logic [OS_CNT_W-1:0]    rx_os_q;
    logic [BIT_CNT_W-1:0]   rx_bit_q;
    logic                   rx_wait_high_q;  // after a low stop bit, ignore the line until it idles high
    logic                   rx_valid_q;
    logic [DATA_BITS-1:0]   rx_data_q;
    logic                   rx_ferr_q;
    logic                   rx_sample;
`ifdef UART_PARITY_EN
    logic                   rx_par_bad_q;
    logic                   rx_perr_q;
    assign uif.Rx_Parity_Error = rx_perr_q;
`else
    assign uif.Rx_Parity_Error = 1'b0;
`endif

    assign rx_sample          = tick && (rx_os_q == OS_LAST);
    assign uif.Rx_Valid       = rx_valid_q;
    assign uif.Rx_Data        = rx_data_q;
    assign uif.Rx_Frame_Error = rx_ferr_q;

    // Two-flop synchroniser on the asynchronous serial input
    always_ff @(posedge Clock_100MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= TXD;
            sync2_q <= sync1_q;
        end
    end

    // RX frame sequencer: start validated at half-bit, later bits sampled at mid-bit
    always_ff @(posedge Clock_100MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            rx_state_q     <= RX_IDLE;
            rx_shift_q     <= '0;
            rx_os_q        <= '0;
            rx_bit_q       <= '0;
            rx_wait_high_q <= 1'b0;
            rx_valid_q     <= 1'b0;
            rx_data_q      <= '0;
            rx_ferr_q      <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_bad_q   <= 1'b0;
            rx_perr_q      <= 1'b0;
`endif
        end else begin
            rx_valid_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_wait_high_q) begin
                        if (sync2_q) rx_wait_high_q <= 1'b0;
                    end else if (!sync2_q) begin
                        rx_os_q    <= '0;
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: if (tick) begin
                    if (rx_os_q == OS_MID) begin
                        rx_os_q    <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= sync2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_os_q <= rx_os_q + OS_CNT_W'(1);
                    end
                end
                RX_DATA: if (rx_sample) begin
                    rx_os_q    <= '0;
                    rx_shift_q <= {sync2_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == DATA_LAST) begin
`ifdef UART_PARITY_EN
                        rx_state_q <= RX_PARITY;
`else
                        rx_state_q <= RX_STOP;
`endif
                    end else begin
                        rx_bit_q <= rx_bit_q + BIT_CNT_W'(1);
                    end
                end else if (tick) begin
                    rx_os_q <= rx_os_q + OS_CNT_W'(1);
                end
`ifdef UART_PARITY_EN
                RX_PARITY: if (rx_sample) begin
                    rx_os_q      <= '0;
                    rx_par_bad_q <= sync2_q ^ (^rx_shift_q) ^ PAR_ODD;
                    rx_state_q   <= RX_STOP;
                end else if (tick) begin
                    rx_os_q <= rx_os_q + OS_CNT_W'(1);
                end
`endif
                RX_STOP: if (rx_sample) begin
                    rx_os_q        <= '0;
                    rx_valid_q     <= 1'b1;
                    rx_data_q      <= rx_shift_q;
                    rx_ferr_q      <= ~sync2_q;
`ifdef UART_PARITY_EN
                    rx_perr_q      <= rx_par_bad_q;
`endif
                    rx_wait_high_q <= ~sync2_q;
                    rx_state_q     <= RX_IDLE;
                end else if (tick) begin
                    rx_os_q <= rx_os_q + OS_CNT_W'(1);
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end
endmodule
